conv_patch_engine: RTL and testbench

CONV_PATCH_ENGINE -- requirements
Module: conv_patch_engine

---
 rtl/conv_patch_engine.sv | 143 ++++++++++++++
 tb/tb_conv_patch_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_patch_engine.sv
// Single-patch KxK convolution engine: fetches one patch from an external image RAM,
// multiply-accumulates it against a locally held signed kernel and emits a ReLU result.
`timescale 1ns/1ps
module conv_patch_engine #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned K      = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 2 * DATA_W + 1 + $clog2(K * K)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             patch_start,
    input  logic [$clog2(IMG_H-K+1)-1:0]     conv_row,
    input  logic [$clog2(IMG_W-K+1)-1:0]     conv_col,
    output logic                             img_rd_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]   img_addr,
    input  logic [DATA_W-1:0]                img_rdata,
    input  logic                             w_wr_en,
    input  logic [$clog2(K*K)-1:0]           w_wr_idx,
    input  logic [DATA_W-1:0]                w_wr_data,
    output logic                             patch_valid,
    output logic [ACC_W-1:0]                 feat_out,
    output logic [$clog2(IMG_H-K+1)-1:0]     feat_row,
    output logic [$clog2(IMG_W-K+1)-1:0]     feat_col,
    output logic                             busy
);

    localparam int unsigned ROW_W  = $clog2(IMG_H - K + 1);
    localparam int unsigned COL_W  = $clog2(IMG_W - K + 1);
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int unsigned IDX_W  = $clog2(K * K);
    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam int unsigned NTAPS  = K * K;

    localparam logic [IDX_W-1:0]  LastTap = IDX_W'(NTAPS - 1);
    localparam logic [IDX_W-1:0]  LastCol = IDX_W'(K - 1);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W - K + 1);

    typedef enum logic [2:0] {StIdle, StLatch, StFetch, StDrain, StOut} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   w_q [NTAPS];
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ADDR_W-1:0]   addr_q, base_addr;
    logic [IDX_W-1:0]    tap_q, col_q, rd_idx_q;
    logic                rd_vld_q;
    logic [ACC_W-1:0]    feat_out_q;
    logic [ROW_W-1:0]    feat_row_q;
    logic [COL_W-1:0]    feat_col_q;

    logic [DATA_W-1:0]        w_cur;
    logic signed [PROD_W-1:0] pix_ext, wgt_ext, prod;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (patch_start) state_d = StLatch;
            StLatch: state_d = StFetch;
            StFetch: if (tap_q == LastTap) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   state_d = patch_start ? StLatch : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read data lags the strobe by one cycle, so the tap index travels with rd_vld_q.
    always_comb begin
        w_cur   = w_q[rd_idx_q];
        pix_ext = signed'({{(PROD_W - DATA_W){1'b0}}, img_rdata});
        wgt_ext = signed'({{(PROD_W - DATA_W){w_cur[DATA_W-1]}}, w_cur});
        prod    = pix_ext * wgt_ext;
        acc_d   = acc_q;
        if (rd_vld_q) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_comb begin
        base_addr = ADDR_W'(conv_row) * ADDR_W'(IMG_W) + ADDR_W'(conv_col);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            for (int t = 0; t < NTAPS; t++) w_q[t] <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            tap_q      <= '0;
            col_q      <= '0;
            rd_idx_q   <= '0;
            rd_vld_q   <= 1'b0;
            feat_out_q <= '0;
            feat_row_q <= '0;
            feat_col_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= (state_q == StFetch);
            rd_idx_q <= tap_q;
            if (state_q == StIdle && w_wr_en && 32'(w_wr_idx) < NTAPS) begin
                w_q[w_wr_idx] <= w_wr_data;
            end
            case (state_q)
                StLatch: begin
                    feat_row_q <= conv_row;
                    feat_col_q <= conv_col;
                    acc_q      <= '0;
                    addr_q     <= base_addr;
                    tap_q      <= '0;
                    col_q      <= '0;
                end
                StFetch: begin
                    acc_q <= acc_d;
                    // Hold the final address so img_addr keeps it after FETCH.
                    if (tap_q != LastTap) begin
                        tap_q <= tap_q + 1'b1;
                        if (col_q == LastCol) begin
                            col_q  <= '0;
                            addr_q <= addr_q + RowStep;
                        end else begin
                            col_q  <= col_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    acc_q      <= acc_d;
                    feat_out_q <= acc_d[ACC_W-1] ? '0 : acc_d;
                end
                default: ;
            endcase
        end
    end

    assign img_rd_en   = (state_q == StFetch);
    assign patch_valid = (state_q == StOut);
    assign busy        = (state_q != StIdle);
    assign img_addr    = addr_q;
    assign feat_out    = feat_out_q;
    assign feat_row    = feat_row_q;
    assign feat_col    = feat_col_q;

endmodule

// File: tb/tb_conv_patch_engine.sv
// Directed bench for conv_patch_engine with a one-cycle-latency image RAM model.
`timescale 1ns/1ps
module tb_conv_patch_engine;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 21;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int ADDR_W = 10;
    localparam int IDX_W  = 4;

    logic              clk;
    logic              reset;
    logic              patch_start;
    logic [ROW_W-1:0]  conv_row;
    logic [COL_W-1:0]  conv_col;
    logic              img_rd_en;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_rdata;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;
    logic              patch_valid;
    logic [ACC_W-1:0]  feat_out;
    logic [ROW_W-1:0]  feat_row;
    logic [COL_W-1:0]  feat_col;
    logic              busy;

    conv_patch_engine #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .patch_start (patch_start),
        .conv_row    (conv_row),
        .conv_col    (conv_col),
        .img_rd_en   (img_rd_en),
        .img_addr    (img_addr),
        .img_rdata   (img_rdata),
        .w_wr_en     (w_wr_en),
        .w_wr_idx    (w_wr_idx),
        .w_wr_data   (w_wr_data),
        .patch_valid (patch_valid),
        .feat_out    (feat_out),
        .feat_row    (feat_row),
        .feat_col    (feat_col),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] img_mem [IMG_W*IMG_H];
    always @(posedge clk) if (img_rd_en) img_rdata <= img_mem[img_addr];

    int checks = 0;
    int errors = 0;
    int addr_log [16];
    int n_rd, lat, first_addr, last_addr, cyc;
    int exp_addr [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < IMG_W * IMG_H; a++) img_mem[a] = 8'(a);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int a = 0; a < IMG_W * IMG_H; a++) img_mem[a] = v;
    endtask

    task automatic load_w(input logic [7:0] v);
        for (int t = 0; t < K * K; t++) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = IDX_W'(t);
            w_wr_data = v;
            step();
        end
        w_wr_en = 1'b0;
    endtask

    // Returns in the cycle patch_valid is seen (or after a 40-cycle bound); cycle 1 is LATCH.
    task automatic run_patch(input int row, input int col, input bit noise);
        conv_row    = ROW_W'(row);
        conv_col    = COL_W'(col);
        patch_start = 1'b1;
        step();
        patch_start = 1'b0;
        n_rd = 0; lat = 0; first_addr = -1; last_addr = -1;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (img_rd_en) begin
                if (n_rd < 16) addr_log[n_rd] = int'(img_addr);
                if (n_rd == 0) first_addr = int'(img_addr);
                last_addr = int'(img_addr);
                n_rd++;
            end
            patch_start = noise & img_rd_en;
            w_wr_en     = noise & img_rd_en;
            w_wr_idx    = 4'd4;
            w_wr_data   = 8'd100;
            if (patch_valid) begin
                lat = c;
                break;
            end
        end
        patch_start = 1'b0;
        w_wr_en     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; patch_start = 1'b0; conv_row = '0; conv_col = '0;
        w_wr_en = 1'b0; w_wr_idx = '0; w_wr_data = '0;
        step();
        step();
        chk("reset busy", 32'(busy), 0);
        chk("reset rd_en", 32'(img_rd_en), 0);
        chk("reset addr", 32'(img_addr), 0);
        chk("reset valid", 32'(patch_valid), 0);
        chk("reset feat_out", 32'(feat_out), 0);
        chk("reset feat_row", 32'(feat_row), 0);
        chk("reset feat_col", 32'(feat_col), 0);
        reset = 1'b1;
        step();

        // Ramp image, unit kernel at (0,0)
        fill_ramp();
        load_w(8'd1);
        run_patch(0, 0, 1'b0);
        chk("ramp latency", lat, 12);
        chk("ramp reads", n_rd, 9);
        for (int t = 0; t < 9; t++) chk("ramp addr", addr_log[t], exp_addr[t]);
        chk("ramp feat", 32'(feat_out), 261);
        chk("ramp row", 32'(feat_row), 0);
        step();
        chk("ramp valid one cycle", 32'(patch_valid), 0);
        chk("ramp idle", 32'(busy), 0);
        chk("ramp feat held", 32'(feat_out), 261);

        // Negative kernel clamps to zero
        load_w(8'hFF);
        run_patch(0, 0, 1'b0);
        chk("neg latency", lat, 12);
        chk("neg feat", 32'(feat_out), 0);
        step();
        chk("neg valid one cycle", 32'(patch_valid), 0);

        // Saturated pixels, extreme weights
        fill_const(8'd255);
        load_w(8'd127);
        run_patch(0, 0, 1'b0);
        chk("max feat", 32'(feat_out), 291465);
        step();
        load_w(8'h80);
        run_patch(0, 0, 1'b0);
        chk("min feat", 32'(feat_out), 0);
        step();

        // Bottom-right corner
        fill_ramp();
        load_w(8'd1);
        run_patch(25, 25, 1'b0);
        chk("corner first addr", first_addr, 725);
        chk("corner last addr", last_addr, 783);
        chk("corner row", 32'(feat_row), 25);
        chk("corner col", 32'(feat_col), 25);
        chk("corner feat", 32'(feat_out), 1410);
        step();

        // Back-to-back: start held in OUT, new coordinates only in the LATCH cycle
        conv_row = '0; conv_col = '0;
        run_patch(0, 0, 1'b0);
        chk("b2b first latency", lat, 12);
        chk("b2b first feat", 32'(feat_out), 261);
        patch_start = 1'b1;
        step();
        patch_start = 1'b0;
        conv_row = 5'd0;
        conv_col = 5'd1;
        chk("b2b latch busy", 32'(busy), 1);
        chk("b2b latch rd_en", 32'(img_rd_en), 0);
        cyc = 1; first_addr = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            cyc++;
            if (img_rd_en && first_addr < 0) first_addr = int'(img_addr);
            if (patch_valid) break;
        end
        chk("b2b second spacing", cyc, 12);
        chk("b2b second first addr", first_addr, 1);
        chk("b2b second feat", 32'(feat_out), 270);
        chk("b2b second col", 32'(feat_col), 1);
        step();
        chk("b2b idle", 32'(busy), 0);

        // patch_start and weight writes while busy are ignored
        run_patch(0, 0, 1'b1);
        chk("busy noise latency", lat, 12);
        chk("busy noise feat", 32'(feat_out), 261);
        step();
        chk("busy noise idle", 32'(busy), 0);
        run_patch(0, 0, 1'b0);
        chk("busy noise weights kept", 32'(feat_out), 261);
        step();

        // Reset in FETCH cycle 5, with start and weight write in the reset cycle
        conv_row = 5'd1; conv_col = 5'd2;
        patch_start = 1'b1;
        step();
        patch_start = 1'b0;
        repeat (6) step();
        chk("mid fetch addr", 32'(img_addr), 60);
        chk("mid fetch busy", 32'(busy), 1);
        reset = 1'b0; patch_start = 1'b1;
        w_wr_en = 1'b1; w_wr_idx = 4'd4; w_wr_data = 8'd5;
        step();
        reset = 1'b1; patch_start = 1'b0; w_wr_en = 1'b0;
        chk("rst busy", 32'(busy), 0);
        chk("rst rd_en", 32'(img_rd_en), 0);
        chk("rst addr", 32'(img_addr), 0);
        chk("rst valid", 32'(patch_valid), 0);
        chk("rst feat_out", 32'(feat_out), 0);
        chk("rst feat_row", 32'(feat_row), 0);
        chk("rst feat_col", 32'(feat_col), 0);
        step();
        chk("rst start ignored", 32'(busy), 0);
        run_patch(0, 0, 1'b0);
        chk("rst latency", lat, 12);
        chk("rst weights cleared", 32'(feat_out), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
